// File: rtl/clk_divider_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master drives enable and divisor requests, and the slave returns the divided clock and status.
interface clk_divider_prog_if #(
  parameter int unsigned DIV_W = 8
);
  logic             en;
  logic             load;
  logic [DIV_W-1:0] div_val;
  logic             clk_div;
  logic             tick;
  logic             load_pending;

  modport master (
    output en, load, div_val,
    input  clk_div, tick, load_pending
  );

  modport slave (
    input  en, load, div_val,
    output clk_div, tick, load_pending
  );
endinterface

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with a per-period tick.
// Divisor updates take effect only at a period boundary, so clk_div cannot glitch.
module clk_divider_prog #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic               clk,
  input  logic               an_rst,
  clk_divider_prog_if.slave  bus
);

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic [DIV_W-1:0] div_clamped;

  // Divisors 0 and 1 cannot produce a valid two-phase clock, so they become 2.
  assign div_clamped = (bus.div_val < MinDiv) ? MinDiv : bus.div_val;

  always_comb begin
    wrap       = bus.en && (cnt_q == div_cur_q - DIV_W'(1));
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    clk_div_d  = clk_div_q;
    tick_d     = 1'b0;

    if (bus.en) begin
      cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
      clk_div_d = (cnt_d >= (div_cur_q >> 1));
      tick_d    = wrap;
    end

    // A load on the wrap edge supersedes any older pending divisor.
    if (bus.load && wrap) begin
      div_cur_d = div_clamped;
      pend_d    = 1'b0;
    end else if (bus.load) begin
      div_pend_d = div_clamped;
      pend_d     = 1'b1;
    end else if (wrap && pend_q) begin
      div_cur_d = div_pend_q;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge an_rst) begin
    if (!an_rst) begin
      cnt_q      <= '0;
      div_cur_q  <= DefDiv;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.clk_div      = clk_div_q;
  assign bus.tick         = tick_q;
  assign bus.load_pending = pend_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: a directed vector table, corner-case sequences,
// and random stimulus compared against a period-position reference model.
module tb_clk_divider_prog;

  logic clk = 1'b0;
  logic an_rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  clk_divider_prog_if #(.DIV_W(8)) bus ();

  clk_divider_prog #(
    .DIV_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk    (clk),
    .an_rst (an_rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] dv;
    logic       clk_div;
    logic       tick;
    logic       pend;
  } vec_t;

  vec_t vecs[20];

  // Reference model: position within the current output period and divisor bookkeeping.
  int m_pos, m_n, m_pend;
  bit m_lp, m_clk, m_tick;

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_n = 2; m_pend = 0; m_lp = 1'b0; m_clk = 1'b0; m_tick = 1'b0;
  endfunction

  function automatic void model_step(input bit e, input bit l, input int dv);
    bit boundary;
    boundary = e && (m_pos + 1 == m_n);
    m_tick   = boundary;
    if (e) m_pos = boundary ? 0 : m_pos + 1;
    if (l && boundary) begin
      m_n = clampv(dv); m_lp = 1'b0;
    end else if (l) begin
      m_pend = clampv(dv); m_lp = 1'b1;
    end else if (boundary && m_lp) begin
      m_n = m_pend; m_lp = 1'b0;
    end
    // The low phase spans the first floor(N/2) positions of each period.
    if (e) m_clk = (m_pos >= m_n / 2);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit e, input bit l, input int dv);
    bus.en      = e;
    bus.load    = l;
    bus.div_val = 8'(dv);
    @(posedge clk);
    model_step(e, l, dv & 255);
    #1;
    check("clk_div", int'(bus.clk_div), int'(m_clk));
    check("tick", int'(bus.tick), int'(m_tick));
    check("load_pending", int'(bus.load_pending), int'(m_lp));
  endtask

  task automatic wait_tick(input int limit);
    int k = 0;
    while (!bus.tick && k < limit) begin
      cycle(1'b1, 1'b0, 0);
      k++;
    end
    check("tick_timeout", int'(bus.tick), 1);
  endtask

  // Cycles from one tick to the next, counting high-phase cycles in between.
  task automatic measure(output int len, output int high);
    len  = 0;
    high = 0;
    do begin
      cycle(1'b1, 1'b0, 0);
      len++;
      if (bus.clk_div) high++;
    end while (!bus.tick && len < 600);
  endtask

  initial begin
    int len, high, maxcnt;
    logic held;

    vecs[0]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};

    bus.en = 1'b0; bus.load = 1'b0; bus.div_val = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_div", int'(bus.clk_div), 0);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_pending", int'(bus.load_pending), 0);
    an_rst = 1'b1;

    // Directed table from reset: N=2, mid-period load 5, clamp during freeze, load on wrap.
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].en, vecs[i].load, int'(vecs[i].dv));
      check($sformatf("vec%0d_clk_div", i), int'(bus.clk_div), int'(vecs[i].clk_div));
      check($sformatf("vec%0d_tick", i), int'(bus.tick), int'(vecs[i].tick));
      check($sformatf("vec%0d_pending", i), int'(bus.load_pending), int'(vecs[i].pend));
    end

    // Two loads before the boundary: only the later one is adopted.
    cycle(1'b1, 1'b1, 7);
    cycle(1'b1, 1'b1, 3);
    check("last_wins_pending", int'(bus.load_pending), 1);
    wait_tick(20);
    measure(len, high);
    check("last_wins_period", len, 3);

    // Freeze mid-period: outputs hold, then the period resumes where it stopped.
    cycle(1'b1, 1'b1, 6);
    wait_tick(20);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    held = bus.clk_div;
    repeat (10) cycle(1'b0, 1'b0, 0);
    check("freeze_hold", int'(bus.clk_div), int'(held));
    len = 3;
    while (!bus.tick && len < 40) begin
      cycle(1'b1, 1'b0, 0);
      len++;
    end
    check("freeze_resume_len", len, 6);

    // Largest divisor: period 255, 128 high cycles, counter bounded.
    cycle(1'b1, 1'b1, 255);
    wait_tick(20);
    maxcnt = 0;
    len = 0;
    high = 0;
    do begin
      cycle(1'b1, 1'b0, 0);
      len++;
      if (bus.clk_div) high++;
      if (int'(dut.cnt_q) > maxcnt) maxcnt = int'(dut.cnt_q);
    end while (!bus.tick && len < 600);
    check("n255_period", len, 255);
    check("n255_high", high, 128);
    check("n255_cnt_max", maxcnt, 254);

    // Clamped divisors behave as N=2.
    cycle(1'b1, 1'b1, 0);
    wait_tick(300);
    measure(len, high);
    check("clamp0_period", len, 2);
    cycle(1'b1, 1'b1, 1);
    wait_tick(10);
    measure(len, high);
    check("clamp1_period", len, 2);
    check("clamp1_high", high, 1);

    // Asynchronous reset between edges with clk_div high and a load pending.
    cycle(1'b1, 1'b1, 5);
    wait_tick(20);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 9);
    #2;
    an_rst = 1'b0;
    #1;
    check("async_clk_div", int'(bus.clk_div), 0);
    check("async_tick", int'(bus.tick), 0);
    check("async_pending", int'(bus.load_pending), 0);
    @(posedge clk);
    #1;
    an_rst = 1'b1;
    model_reset();
    measure(len, high);
    check("post_reset_period", len, 2);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int dv;
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 9));
      cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 6, dv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
